// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave in front of a small bank of 32-bit registers.
// Independent write and read FSMs.
//
// Write FSM
//   state       | meaning
//   W_IDLE      | waiting for an address and data beat, accepts either or both
//   W_HAVE_ADDR | address captured, waiting for the data beat
//   W_HAVE_DATA | data captured, waiting for the address beat
//   W_RESP      | register committed, holding bvalid until bready
// Read FSM
//   state       | meaning
//   R_IDLE      | arready high, waiting for a read address
//   R_DATA      | rdata/rresp registered, holding rvalid until rready
module axi_lite_regfile_slave #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_REGS   = 16
) (
   input  logic                    aclk,
   input  logic                    areset,
   input  logic [ADDR_WIDTH-1:0]   awaddr,
   input  logic                    awvalid,
   output logic                    awready,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    wvalid,
   output logic                    wready,
   output logic [1:0]              bresp,
   output logic                    bvalid,
   input  logic                    bready,
   input  logic [ADDR_WIDTH-1:0]   araddr,
   input  logic                    arvalid,
   output logic                    arready,
   output logic [DATA_WIDTH-1:0]   rdata,
   output logic [1:0]              rresp,
   output logic                    rvalid,
   input  logic                    rready
);
   localparam int IDX_W  = $clog2(NUM_REGS);
   localparam int STRB_W = DATA_WIDTH / 8;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {W_IDLE, W_HAVE_ADDR, W_HAVE_DATA, W_RESP} w_state_e;
   typedef enum logic {R_IDLE, R_DATA} r_state_e;

   // Any set bit above the index field means the access misses the bank.
   function automatic logic addr_oor(input logic [ADDR_WIDTH-1:0] a);
      return |(a >> (2 + IDX_W));
   endfunction

   function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_WIDTH-1:0] a);
      return a[2+IDX_W-1:2];
   endfunction

   w_state_e              w_state_q, w_state_d;
   r_state_e              r_state_q, r_state_d;
   logic [IDX_W-1:0]      aw_idx_q, aw_idx_d;
   logic                  aw_oor_q, aw_oor_d;
   logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
   logic [STRB_W-1:0]     wstrb_q, wstrb_d;
   logic [1:0]            bresp_q, bresp_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic [1:0]            rresp_q, rresp_d;
   logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
   logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];
   logic                  rst_done_q, rst_done_d;
   logic                  aw_hs, w_hs, ar_hs, commit;
   logic                  unused_addr_bits;

   // Byte-lane bits of the address carry no meaning for word registers.
   assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

   // Readies stay low until the first clock edge after reset release.
   assign rst_done_d = 1'b1;

   assign awready = rst_done_q && (w_state_q == W_IDLE || w_state_q == W_HAVE_DATA);
   assign wready  = rst_done_q && (w_state_q == W_IDLE || w_state_q == W_HAVE_ADDR);
   assign arready = rst_done_q && (r_state_q == R_IDLE);
   assign bvalid  = (w_state_q == W_RESP);
   assign rvalid  = (r_state_q == R_DATA);
   assign bresp   = bresp_q;
   assign rdata   = rdata_q;
   assign rresp   = rresp_q;

   assign aw_hs = awvalid && awready;
   assign w_hs  = wvalid && wready;
   assign ar_hs = arvalid && arready;

   // Write FSM next state, beat capture and register commit on entry to W_RESP.
   always_comb begin
      w_state_d = w_state_q;
      aw_idx_d  = aw_idx_q;
      aw_oor_d  = aw_oor_q;
      wdata_d   = wdata_q;
      wstrb_d   = wstrb_q;
      bresp_d   = bresp_q;
      regs_d    = regs_q;
      commit    = 1'b0;
      if (aw_hs) begin
         aw_idx_d = addr_idx(awaddr);
         aw_oor_d = addr_oor(awaddr);
      end
      if (w_hs) begin
         wdata_d = wdata;
         wstrb_d = wstrb;
      end
      case (w_state_q)
         W_IDLE: begin
            if (aw_hs && w_hs) w_state_d = W_RESP;
            else if (aw_hs)    w_state_d = W_HAVE_ADDR;
            else if (w_hs)     w_state_d = W_HAVE_DATA;
         end
         W_HAVE_ADDR: if (w_hs)   w_state_d = W_RESP;
         W_HAVE_DATA: if (aw_hs)  w_state_d = W_RESP;
         W_RESP:      if (bready) w_state_d = W_IDLE;
         default:                 w_state_d = W_IDLE;
      endcase
      commit = (w_state_q != W_RESP) && (w_state_d == W_RESP);
      if (commit) begin
         bresp_d = aw_oor_d ? RESP_SLVERR : RESP_OKAY;
         if (!aw_oor_d) begin
            for (int b = 0; b < STRB_W; b++) begin
               if (wstrb_d[b]) regs_d[aw_idx_d][8*b +: 8] = wdata_d[8*b +: 8];
            end
         end
      end
   end

   // Read FSM next state; data is sampled from the pre-commit register value.
   always_comb begin
      r_state_d = r_state_q;
      rdata_d   = rdata_q;
      rresp_d   = rresp_q;
      case (r_state_q)
         R_IDLE: begin
            if (ar_hs) begin
               r_state_d = R_DATA;
               rdata_d   = addr_oor(araddr) ? '0 : regs_q[addr_idx(araddr)];
               rresp_d   = addr_oor(araddr) ? RESP_SLVERR : RESP_OKAY;
            end
         end
         R_DATA:  if (rready) r_state_d = R_IDLE;
         default: r_state_d = R_IDLE;
      endcase
   end

   // State, capture and register-bank flops; reset aborts any transaction.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         w_state_q  <= W_IDLE;
         r_state_q  <= R_IDLE;
         aw_idx_q   <= '0;
         aw_oor_q   <= 1'b0;
         wdata_q    <= '0;
         wstrb_q    <= '0;
         bresp_q    <= '0;
         rdata_q    <= '0;
         rresp_q    <= '0;
         rst_done_q <= 1'b0;
         regs_q     <= '{default: '0};
      end else begin
         w_state_q  <= w_state_d;
         r_state_q  <= r_state_d;
         aw_idx_q   <= aw_idx_d;
         aw_oor_q   <= aw_oor_d;
         wdata_q    <= wdata_d;
         wstrb_q    <= wstrb_d;
         bresp_q    <= bresp_d;
         rdata_q    <= rdata_d;
         rresp_q    <= rresp_d;
         rst_done_q <= rst_done_d;
         regs_q     <= regs_d;
      end
   end
endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Directed bench for axi_lite_regfile_slave with a B/R response scoreboard.
module tb_axi_lite_regfile_slave;
   logic        aclk = 1'b0;
   logic        areset = 1'b1;
   logic [31:0] awaddr = '0;
   logic        awvalid = 1'b0;
   logic        awready;
   logic [31:0] wdata = '0;
   logic [3:0]  wstrb = '0;
   logic        wvalid = 1'b0;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready = 1'b1;
   logic [31:0] araddr = '0;
   logic        arvalid = 1'b0;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready = 1'b1;

   int n_cmp = 0;
   int n_err = 0;
   logic [1:0]  bq [$];
   logic [33:0] rq [$];

   axi_lite_regfile_slave #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
      .aclk(aclk), .areset(areset),
      .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
      .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
      .bresp(bresp), .bvalid(bvalid), .bready(bready),
      .araddr(araddr), .arvalid(arvalid), .arready(arready),
      .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare whenever a B or R handshake is about to complete.
   always @(negedge aclk) begin
      if (!areset) begin
         if (bvalid && bready) begin
            if (bq.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_b: got bresp %b expected no response", bresp);
            end else begin
               chk("bresp", {62'd0, bresp}, {62'd0, bq.pop_front()});
            end
         end
         if (rvalid && rready) begin
            if (rq.size() == 0) begin
               n_cmp++; n_err++;
               $display("FAIL unexpected_r: got rdata %h expected no response", rdata);
            end else begin
               chk("rdata_rresp", {30'd0, rdata, rresp}, {30'd0, rq.pop_front()});
            end
         end
      end
   end

   // Hold the requested valids until each is accepted (bounded).
   task automatic do_hs(input bit a, input bit w, input bit r);
      bit ha, hw, hr;
      awvalid = a; wvalid = w; arvalid = r;
      for (int i = 0; i < 20; i++) begin
         if (!awvalid && !wvalid && !arvalid) break;
         @(negedge aclk);
         ha = awvalid && awready; hw = wvalid && wready; hr = arvalid && arready;
         @(posedge aclk); #1;
         if (ha) awvalid = 1'b0;
         if (hw) wvalid = 1'b0;
         if (hr) arvalid = 1'b0;
      end
      if (awvalid || wvalid || arvalid) begin
         n_cmp++; n_err++;
         $display("FAIL hs_timeout: got valids %b%b%b still pending expected 000", awvalid, wvalid, arvalid);
         awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      for (int i = 0; i < 20; i++) begin
         if (bq.size() == 0 && rq.size() == 0) break;
         @(posedge aclk); #1;
      end
      if (bq.size() != 0 || rq.size() != 0) begin
         n_cmp++; n_err++;
         $display("FAIL resp_timeout: got %0d/%0d pending expected 0/0", bq.size(), rq.size());
         bq.delete(); rq.delete();
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s, input logic [1:0] er);
      bq.push_back(er);
      awaddr = a; wdata = d; wstrb = s;
      do_hs(1, 1, 0);
      chk("b_latency", {63'd0, bvalid}, 64'd1);
      wait_drain();
   endtask

   task automatic rd(input logic [31:0] a, input logic [31:0] ed, input logic [1:0] er);
      rq.push_back({ed, er});
      araddr = a;
      do_hs(0, 0, 1);
      wait_drain();
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_awready"}, {63'd0, awready}, 64'd0);
      chk({tag, "_wready"},  {63'd0, wready},  64'd0);
      chk({tag, "_arready"}, {63'd0, arready}, 64'd0);
      chk({tag, "_bvalid"},  {63'd0, bvalid},  64'd0);
      chk({tag, "_rvalid"},  {63'd0, rvalid},  64'd0);
      chk({tag, "_bresp"},   {62'd0, bresp},   64'd0);
      chk({tag, "_rresp"},   {62'd0, rresp},   64'd0);
      chk({tag, "_rdata"},   {32'd0, rdata},   64'd0);
   endtask

   task automatic chk_readies(input string tag);
      chk({tag, "_awready"}, {63'd0, awready}, 64'd1);
      chk({tag, "_wready"},  {63'd0, wready},  64'd1);
      chk({tag, "_arready"}, {63'd0, arready}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got time %0t expected finish earlier", $time);
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge aclk);
      chk_all_zero("rst");
      @(posedge aclk); #1; areset = 1'b0;
      @(posedge aclk); #1;
      chk_readies("rst_release");

      // Joint write then read back
      wr(32'h08, 32'hDEADBEEF, 4'hF, 2'b00);
      rd(32'h08, 32'hDEADBEEF, 2'b00);

      // W two cycles ahead of AW with partial strobes
      wr(32'h04, 32'hFFFFFFFF, 4'hF, 2'b00);
      bq.push_back(2'b00);
      wdata = 32'h11223344; wstrb = 4'b0101; awaddr = 32'h04;
      do_hs(0, 1, 0);
      chk("w_only_wready", {63'd0, wready}, 64'd0);
      chk("w_only_bvalid", {63'd0, bvalid}, 64'd0);
      @(posedge aclk); #1;
      do_hs(1, 0, 0);
      chk("late_aw_bvalid", {63'd0, bvalid}, 64'd1);
      wait_drain();
      rd(32'h04, 32'hFF22FF44, 2'b00);

      // Out-of-range access leaves bank untouched
      wr(32'h40, 32'h12345678, 4'hF, 2'b10);
      rd(32'h40, 32'h0, 2'b10);
      rd(32'h00, 32'h0, 2'b00);
      rd(32'h04, 32'hFF22FF44, 2'b00);
      rd(32'h08, 32'hDEADBEEF, 2'b00);

      // Zero strobe is acknowledged but changes nothing; low address bits ignored
      wr(32'h08, 32'h00000000, 4'h0, 2'b00);
      rd(32'h0B, 32'hDEADBEEF, 2'b00);

      // Read response stalled by rready for 5 cycles
      wr(32'h00, 32'hCAFEF00D, 4'hF, 2'b00);
      rready = 1'b0;
      rq.push_back({32'hCAFEF00D, 2'b00});
      araddr = 32'h00;
      do_hs(0, 0, 1);
      araddr = 32'h08; arvalid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge aclk);
         chk("stall_rvalid",  {63'd0, rvalid},  64'd1);
         chk("stall_rdata",   {32'd0, rdata},   {32'd0, 32'hCAFEF00D});
         chk("stall_arready", {63'd0, arready}, 64'd0);
      end
      @(posedge aclk); #1;
      arvalid = 1'b0; rready = 1'b1;
      wait_drain();
      @(negedge aclk);
      chk("no_second_ar", {63'd0, rvalid}, 64'd0);
      @(posedge aclk); #1;

      // Read coinciding with the commit of the same register sees the old value
      bq.push_back(2'b00);
      rq.push_back({32'h0, 2'b00});
      awaddr = 32'h0C; wdata = 32'hA5A5A5A5; wstrb = 4'hF; araddr = 32'h0C;
      do_hs(1, 1, 1);
      wait_drain();
      rd(32'h0C, 32'hA5A5A5A5, 2'b00);

      // Reset while holding a captured address
      awaddr = 32'h10; wdata = 32'h77777777; wstrb = 4'hF;
      do_hs(1, 0, 0);
      chk("have_addr_awready", {63'd0, awready}, 64'd0);
      areset = 1'b1;
      @(negedge aclk);
      chk_all_zero("mid_rst");
      @(posedge aclk); @(posedge aclk); #1;
      areset = 1'b0;
      @(posedge aclk); #1;
      chk_readies("mid_rst_release");
      wr(32'h14, 32'h00000055, 4'hF, 2'b00);
      rd(32'h10, 32'h0, 2'b00);
      rd(32'h14, 32'h00000055, 2'b00);
      rd(32'h08, 32'h0, 2'b00);

      chk("bq_empty", 64'(bq.size()), 64'd0);
      chk("rq_empty", 64'(rq.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/axi_lite_regfile_slave.md
AXI_LITE_REGFILE_SLAVE -- requirements
Module: axi_lite_regfile_slave

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 32: AXI address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32: AXI data width; only 32 is supported.
REQ-003 SHALL have parameter NUM_REGS, default 16: register count; must be a power of 2.
REQ-004 SHALL have port aclk, input, 1: single clock, rising edge.
REQ-005 SHALL have port areset, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have ports awaddr, input, ADDR_WIDTH; awvalid, input, 1; awready, output, 1: write-address channel.
REQ-007 SHALL have ports wdata, input, DATA_WIDTH; wstrb, input, DATA_WIDTH/8; wvalid, input, 1; wready, output, 1: write-data channel.
REQ-008 SHALL have ports bresp, output, 2; bvalid, output, 1; bready, input, 1: write-response channel.
REQ-009 SHALL have ports araddr, input, ADDR_WIDTH; arvalid, input, 1; arready, output, 1: read-address channel.
REQ-010 SHALL have ports rdata, output, DATA_WIDTH; rresp, output, 2; rvalid, output, 1; rready, input, 1: read-data channel.

Function
REQ-011 SHALL decode the register index as addr[2+log2(NUM_REGS)-1:2]; addr[1:0] are ignored.
REQ-012 SHALL treat any address with a set bit at or above bit 2+log2(NUM_REGS) as out of range.
REQ-013 Write FSM SHALL use states W_IDLE, W_HAVE_ADDR, W_HAVE_DATA and W_RESP.
REQ-014 SHALL drive awready=1 in W_IDLE and W_HAVE_DATA only, and wready=1 in W_IDLE and W_HAVE_ADDR only.
REQ-015 On an AW handshake alone, SHALL capture awaddr; W_IDLE->W_HAVE_ADDR, W_HAVE_DATA->W_RESP.
REQ-016 On a W handshake alone, SHALL capture wdata/wstrb; W_IDLE->W_HAVE_DATA, W_HAVE_ADDR->W_RESP.
REQ-017 On AW and W handshakes in the same W_IDLE cycle, SHALL go directly to W_RESP.
REQ-018 SHALL commit the register write on the clock edge that enters W_RESP.
REQ-019 The write SHALL update only the bytes whose wstrb bit is 1; wstrb=0 leaves the register unchanged but is still acknowledged with OKAY.
REQ-020 In W_RESP, SHALL hold bvalid=1 with bresp stable: OKAY (2'b00) for in-range, SLVERR (2'b10) for out-of-range.
REQ-021 An out-of-range write SHALL modify no register.
REQ-022 On bvalid&&bready, SHALL return to W_IDLE; bvalid deasserts the next cycle.
REQ-023 Minimum write latency SHALL be 1 cycle from the joint AW/W handshake to bvalid, giving one transaction per 2 cycles.
REQ-024 Read FSM SHALL use states R_IDLE and R_DATA, with arready=1 only in R_IDLE.
REQ-025 On an AR handshake, SHALL register rdata/rresp and enter R_DATA, so rvalid=1 the next cycle (latency 1).
REQ-026 An out-of-range read SHALL return rdata=0 and rresp=SLVERR.
REQ-027 rdata/rresp SHALL stay stable while rvalid=1 and rready=0; on rvalid&&rready, SHALL return to R_IDLE.
REQ-028 Read and write FSMs SHALL run independently.
REQ-029 If an AR handshake coincides with the write commit to the same register, rdata SHALL be the pre-write value.
REQ-030 Handshake-input values while the matching ready is 0 SHALL be ignored.

Reset
REQ-031 While areset=1, SHALL force all registers to 0, both FSMs to idle, and awready, wready, arready, bvalid and rvalid to 0.
REQ-032 While areset=1, SHALL force bresp, rresp and rdata to 0.
REQ-033 From the first aclk edge after areset falls, awready, wready and arready SHALL be 1.
REQ-034 Reset asserted mid-transaction SHALL abort it; a partially captured write SHALL not be committed.

Verification
REQ-035 Joint AW/W write to 0x08, data 0xDEADBEEF, wstrb 4'hF, bready=1 -> bvalid next cycle with bresp=00; a later read of 0x08 returns 0xDEADBEEF with rresp=00.
REQ-036 W two cycles before AW (addr 0x04, data 0x11223344, wstrb 4'b0101) onto 0x04 preloaded with 0xFFFFFFFF -> wready low after the W handshake; a later read returns 0xFF22FF44.
REQ-037 Write to 0x40 and read from 0x40 with NUM_REGS=16 -> bresp=10, rresp=10, rdata=0, no register changed.
REQ-038 rready held 0 for 5 cycles after a read of 0x00 -> rvalid and rdata stable for all 5 cycles, arready=0, and no second AR accepted.
REQ-039 AR to 0x0C in the same cycle as the write commit of 0x0C (old 0x0, new 0xA5A5A5A5) -> rdata=0x0; a subsequent read returns 0xA5A5A5A5.
REQ-040 areset pulsed while in W_HAVE_ADDR -> all outputs 0 during reset, no register written, and ready signals 1 one cycle after release.
